// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Brief    : Launches one divide at a time on the signed or unsigned
//            AXI-stream divider IP and holds the result until EXE takes it.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic        req_signed,
   input  logic [31:0] req_dividend,
   input  logic [31:0] req_divisor,
   output logic        req_ready,
   input  logic        flush,
   output logic        res_valid,
   output logic [31:0] res_quotient,
   output logic [31:0] res_remainder,
   input  logic        res_ack,
   output logic        busy,
   output logic [31:0] dividend_tdata,
   output logic [31:0] divisor_tdata,
   output logic        s_dividend_tvalid,
   output logic        s_divisor_tvalid,
   input  logic        s_dividend_tready,
   input  logic        s_divisor_tready,
   output logic        u_dividend_tvalid,
   output logic        u_divisor_tvalid,
   input  logic        u_dividend_tready,
   input  logic        u_divisor_tready,
   input  logic        s_dout_tvalid,
   input  logic [63:0] s_dout_tdata,
   input  logic        u_dout_tvalid,
   input  logic [63:0] u_dout_tdata
);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_SEND = 2'd1;
   localparam logic [1:0] C_WAIT = 2'd2;
   localparam logic [1:0] C_DONE = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic        r_kill;
   logic        r_signed;
   logic [31:0] r_dividend;
   logic [31:0] r_divisor;
   logic        r_dvd_valid;
   logic        r_dvs_valid;
   logic [31:0] r_quotient;
   logic [31:0] r_remainder;

   logic        w_accept;
   logic        w_dvd_hs;
   logic        w_dvs_hs;
   logic        w_sent;
   logic        w_in_flight;
   logic        w_dout_valid;
   logic [63:0] w_dout_data;
   logic        w_drop;

   // Only the IP chosen at accept time is driven or listened to.
   assign w_dvd_hs     = r_dvd_valid && (r_signed ? s_dividend_tready : u_dividend_tready);
   assign w_dvs_hs     = r_dvs_valid && (r_signed ? s_divisor_tready  : u_divisor_tready);
   assign w_sent       = (!r_dvd_valid || w_dvd_hs) && (!r_dvs_valid || w_dvs_hs);
   assign w_dout_valid = r_signed ? s_dout_tvalid : u_dout_tvalid;
   assign w_dout_data  = r_signed ? s_dout_tdata  : u_dout_tdata;
   assign w_in_flight  = (r_state == C_SEND) || (r_state == C_WAIT);
   assign w_drop       = r_kill || flush;
   assign w_accept     = req_valid && req_ready;

   assign dividend_tdata    = r_dividend;
   assign divisor_tdata     = r_divisor;
   assign s_dividend_tvalid = r_dvd_valid &&  r_signed;
   assign s_divisor_tvalid  = r_dvs_valid &&  r_signed;
   assign u_dividend_tvalid = r_dvd_valid && !r_signed;
   assign u_divisor_tvalid  = r_dvs_valid && !r_signed;
   assign res_quotient      = r_quotient;
   assign res_remainder     = r_remainder;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         C_IDLE: if (w_accept) w_next = C_SEND;
         C_SEND: begin
            if (w_dout_valid)  w_next = w_drop ? C_IDLE : C_DONE;
            else if (w_sent)   w_next = C_WAIT;
         end
         C_WAIT: if (w_dout_valid) w_next = w_drop ? C_IDLE : C_DONE;
         C_DONE: if (res_ack || flush) w_next = C_IDLE;
         default: w_next = C_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         C_IDLE: begin
            req_ready = !flush;
            busy      = 1'b0;
         end
         C_DONE:  res_valid = 1'b1;
         default: ;
      endcase
   end

   // A tvalid, once raised, stays up until its own handshake, flush or not.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_signed    <= 1'b0;
         r_dividend  <= 32'd0;
         r_divisor   <= 32'd0;
         r_dvd_valid <= 1'b0;
         r_dvs_valid <= 1'b0;
         r_kill      <= 1'b0;
         r_quotient  <= 32'd0;
         r_remainder <= 32'd0;
      end else begin
         if (w_accept) begin
            r_signed    <= req_signed;
            r_dividend  <= req_dividend;
            r_divisor   <= req_divisor;
            r_dvd_valid <= 1'b1;
            r_dvs_valid <= 1'b1;
         end else begin
            if (w_dvd_hs) r_dvd_valid <= 1'b0;
            if (w_dvs_hs) r_dvs_valid <= 1'b0;
         end

         if (w_in_flight && w_dout_valid) begin
            r_kill <= 1'b0;
         end else if (w_in_flight && flush) begin
            r_kill <= 1'b1;
         end

         if (w_in_flight && w_dout_valid && !w_drop) begin
            r_quotient  <= w_dout_data[63:32];
            r_remainder <= w_dout_data[31:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Brief    : Directed plus random bench for div_ctrl with behavioural IPs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_signed;
   logic [31:0] req_dividend;
   logic [31:0] req_divisor;
   logic        req_ready;
   logic        flush;
   logic        res_valid;
   logic [31:0] res_quotient;
   logic [31:0] res_remainder;
   logic        res_ack;
   logic        busy;
   logic [31:0] dividend_tdata;
   logic [31:0] divisor_tdata;
   logic        s_dividend_tvalid, s_divisor_tvalid;
   logic        u_dividend_tvalid, u_divisor_tvalid;
   logic [3:0]  tv;
   logic [3:0]  tr;
   logic [3:0]  rdy_fix;
   logic [3:0]  rnd;
   logic        rdy_rand;
   logic [1:0]  dout_v;
   logic [63:0] dout_d [2];

   int errors = 0;
   int checks = 0;

   // Index map: 0 u_dividend, 1 u_divisor, 2 s_dividend, 3 s_divisor.
   assign tv = {s_divisor_tvalid, s_dividend_tvalid, u_divisor_tvalid, u_dividend_tvalid};
   assign tr = rdy_rand ? rnd : rdy_fix;

   div_ctrl dut (
      .clk               (clk),
      .resetn            (resetn),
      .req_valid         (req_valid),
      .req_signed        (req_signed),
      .req_dividend      (req_dividend),
      .req_divisor       (req_divisor),
      .req_ready         (req_ready),
      .flush             (flush),
      .res_valid         (res_valid),
      .res_quotient      (res_quotient),
      .res_remainder     (res_remainder),
      .res_ack           (res_ack),
      .busy              (busy),
      .dividend_tdata    (dividend_tdata),
      .divisor_tdata     (divisor_tdata),
      .s_dividend_tvalid (s_dividend_tvalid),
      .s_divisor_tvalid  (s_divisor_tvalid),
      .s_dividend_tready (tr[2]),
      .s_divisor_tready  (tr[3]),
      .u_dividend_tvalid (u_dividend_tvalid),
      .u_divisor_tvalid  (u_divisor_tvalid),
      .u_dividend_tready (tr[0]),
      .u_divisor_tready  (tr[1]),
      .s_dout_tvalid     (dout_v[1]),
      .s_dout_tdata      (dout_d[1]),
      .u_dout_tvalid     (dout_v[0]),
      .u_dout_tdata      (dout_d[0])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference arithmetic; a zero divisor yields a fixed marker the IP model passes through.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      logic [31:0] q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   // Behavioural divider IPs: take one word per channel, answer lat_cfg+1 cycles later.
   int         lat_cfg = 0;
   logic [1:0] got_a, got_b;
   logic [31:0] opa [2];
   logic [31:0] opb [2];
   int          cnt [2];

   always @(posedge clk) rnd <= 4'($urandom);

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         got_a  <= 2'b00;
         got_b  <= 2'b00;
         dout_v <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            cnt[k]    <= 0;
            dout_d[k] <= 64'd0;
            opa[k]    <= 32'd0;
            opb[k]    <= 32'd0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            dout_v[k] <= 1'b0;
            if (tv[2*k] && tr[2*k]) begin
               got_a[k] <= 1'b1;
               opa[k]   <= dividend_tdata;
            end
            if (tv[2*k+1] && tr[2*k+1]) begin
               got_b[k] <= 1'b1;
               opb[k]   <= divisor_tdata;
            end
            if (got_a[k] && got_b[k]) begin
               if (cnt[k] >= lat_cfg) begin
                  dout_v[k] <= 1'b1;
                  dout_d[k] <= ref_div(k == 1, opa[k], opb[k]);
                  got_a[k]  <= 1'b0;
                  got_b[k]  <= 1'b0;
                  cnt[k]    <= 0;
               end else begin
                  cnt[k] <= cnt[k] + 1;
               end
            end
         end
      end
   end

   // Bus observer: per-channel counters and event timestamps.
   logic        cur_sgn = 1'b0;
   logic [31:0] cur_a = 32'd0;
   logic [31:0] cur_b = 32'd0;
   int hi_cnt [4];
   int hs_cnt [4];
   int wrong_cnt = 0;
   int bad_data = 0;
   int res_hi = 0;
   int cyc = 0;
   int dout_cyc = -100;
   int rise_cyc = -200;
   logic res_prev = 1'b0;

   always @(posedge clk) begin
      if (resetn) begin
         for (int k = 0; k < 4; k++) begin
            if (tv[k]) hi_cnt[k]++;
            if (tv[k] && tr[k]) hs_cnt[k]++;
         end
         if (cur_sgn ? (tv[1:0] != 2'b00) : (tv[3:2] != 2'b00)) wrong_cnt++;
         if ((tv[0] || tv[2]) && dividend_tdata !== cur_a) bad_data++;
         if ((tv[1] || tv[3]) && divisor_tdata !== cur_b) bad_data++;
         if (cur_sgn ? dout_v[1] : dout_v[0]) dout_cyc = cyc;
         if (res_valid && !res_prev) rise_cyc = cyc;
         if (res_valid) res_hi++;
      end
      res_prev = res_valid;
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int hs0 [4];
   int hi0 [4];

   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int lat);
      int n;
      for (int k = 0; k < 4; k++) begin
         hs0[k] = hs_cnt[k];
         hi0[k] = hi_cnt[k];
      end
      cur_sgn      = sgn;
      cur_a        = a;
      cur_b        = b;
      lat_cfg      = lat;
      req_signed   = sgn;
      req_dividend = a;
      req_divisor  = b;
      req_valid    = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 20);
      req_valid = 1'b0;
      check("accept", busy, 1);
   endtask

   task automatic finish_op(input int hold, input logic exit_flush);
      logic [63:0] exp;
      int n;
      int base;
      exp = ref_div(cur_sgn, cur_a, cur_b);
      base = cur_sgn ? 2 : 0;
      n = 0;
      while (!res_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("res_valid", res_valid, 1);
      check("quotient", res_quotient, exp[63:32]);
      check("remainder", res_remainder, exp[31:0]);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         @(negedge clk);
         check("hold_q", {res_valid, busy, req_ready, res_quotient, res_remainder[28:0]},
               {1'b1, 1'b1, 1'b0, exp[63:32], exp[28:0]});
      end
      req_valid = 1'b1;
      if (exit_flush) flush = 1'b1;
      else            res_ack = 1'b1;
      @(negedge clk);
      res_ack   = 1'b0;
      flush     = 1'b0;
      req_valid = 1'b0;
      check("idle_after_ack", {busy, res_valid}, 2'b00);
      check("latency", rise_cyc - dout_cyc, 1);
      check("hs_count", {hs_cnt[base] - hs0[base], hs_cnt[base+1] - hs0[base+1]}, {32'd1, 32'd1});
      check("wrong_ip", wrong_cnt, 0);
      check("data_stable", bad_data, 0);
   endtask

   int r0;
   int n;

   initial begin
      resetn       = 1'b0;
      req_valid    = 1'b0;
      req_signed   = 1'b0;
      req_dividend = 32'd0;
      req_divisor  = 32'd0;
      flush        = 1'b0;
      res_ack      = 1'b0;
      rdy_rand     = 1'b0;
      rdy_fix      = 4'b1111;

      @(negedge clk);
      check("rst_ctrl", {req_ready, busy, res_valid}, 3'b100);
      check("rst_tvalid", tv, 4'b0000);
      check("rst_result", {res_quotient, res_remainder}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Signed -7 / 2 with immediate ready.
      start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 2);
      check("sgn_tvalid", tv, 4'b1100);
      finish_op(0, 1'b0);
      check("sgn_q_const", res_quotient, 32'hFFFF_FFFD);
      check("sgn_r_const", res_remainder, 32'hFFFF_FFFF);

      // Unsigned 0xFFFFFFFF / 16.
      start_op(1'b0, 32'hFFFF_FFFF, 32'd16, 1);
      finish_op(1, 1'b0);
      check("u_q_const", {res_quotient, res_remainder}, {32'h0FFF_FFFF, 32'h0000_000F});

      // Divisor channel stalled for three cycles.
      rdy_fix = 4'b1101;
      start_op(1'b0, 32'd77, 32'd5, 0);
      check("stall_tv0", tv, 4'b0011);
      @(negedge clk);
      check("stall_tv1", tv, 4'b0010);
      @(negedge clk);
      @(negedge clk);
      rdy_fix = 4'b1111;
      finish_op(0, 1'b0);
      check("stall_hi", {hi_cnt[0] - hi0[0], hi_cnt[1] - hi0[1]}, {32'd1, 32'd4});

      // Flush two cycles after the handshake while waiting for the IP.
      r0 = res_hi;
      start_op(1'b1, 32'd50, 32'd3, 6);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n = 0;
      while (!dout_v[1] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("flush_dout_seen", dout_v[1], 1);
      @(negedge clk);
      check("flush_idle", {busy, res_hi - r0}, {1'b0, 32'd0});
      start_op(1'b1, 32'd100, 32'd7, 2);
      finish_op(0, 1'b0);
      check("after_flush", {res_quotient, res_remainder}, {32'd14, 32'd2});

      // Flush arriving in the same cycle as the IP result.
      r0 = res_hi;
      start_op(1'b0, 32'd900, 32'd9, 3);
      n = 0;
      while (!dout_v[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_same_cycle", {busy, res_hi - r0}, {1'b0, 32'd0});

      // Result held in DONE for five cycles.
      start_op(1'b0, 32'd1000, 32'd3, 1);
      finish_op(5, 1'b0);

      // Flush in IDLE blocks the request.
      flush        = 1'b1;
      req_valid    = 1'b1;
      #1;
      check("flush_idle_ready", req_ready, 0);
      @(negedge clk);
      check("flush_idle_block", busy, 0);
      flush     = 1'b0;
      req_valid = 1'b0;

      // Asynchronous reset while stuck in SEND.
      rdy_fix = 4'b0000;
      start_op(1'b1, 32'd9, 32'd2, 0);
      check("send_tvalid", tv, 4'b1100);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst", {tv, res_valid, busy}, 6'b0);
      @(negedge clk);
      resetn  = 1'b1;
      rdy_fix = 4'b1111;
      @(negedge clk);
      start_op(1'b1, 32'd9, 32'd2, 0);
      finish_op(0, 1'b0);
      check("post_rst", {res_quotient, res_remainder}, {32'd4, 32'd1});

      // Random operations with random ready back-pressure.
      rdy_rand = 1'b1;
      for (int i = 0; i < 14; i++) begin
         logic        sg;
         logic [31:0] a, b;
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         if (sg && b == 32'hFFFF_FFFF) b = 32'd5;
         start_op(sg, a, b, $urandom_range(0, 4));
         finish_op($urandom_range(0, 2), (i % 4) == 3);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
